tree_adder_seq: RTL and testbench

Sequencer for the single-level recirculating tree adder. Accepts a frame-reduction request selecting one of the three pixel planes (mult, shadowA, shadowB). It then drives the adder's `cmdinput` through one load cycle and log2(IMGSIDELENGTH) reduce passes, which collapse the frame into pixel [0][0]. It captures that pixel and returns it over a valid/ready handshake. It sits between the frame-level controller and the adder array and is the only driver of `cmdinput`.

---
 rtl/tree_adder_seq.sv | 155 +++++++++++++++
 tb/tb_tree_adder_seq.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tree_adder_seq.sv
// Sequencer for the single-level recirculating tree adder: load one pixel plane, run
// log2(IMGSIDELENGTH) reduce passes, capture pixel [0][0], return it over valid/ready.
// Optional saturating result accumulator enabled by defining TREE_SEQ_ACCUM_EN.
module tree_adder_seq #(
    parameter int unsigned IMGSIDELENGTH  = 64,
    parameter int unsigned ADDER_DATASIZE = 16,
    parameter int unsigned CMD_WIDTH      = 4,
    localparam int unsigned NPASS         = $clog2(IMGSIDELENGTH),
    localparam int unsigned PASS_W        = $clog2(NPASS + 1)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [1:0]                src_sel,
    input  logic                      abort,
    input  logic [ADDER_DATASIZE-1:0] result_pix,
    input  logic                      result_ready,
`ifdef TREE_SEQ_ACCUM_EN
    input  logic                      acc_clear,
    output logic [ADDER_DATASIZE+7:0] acc_out,
`endif
    output logic [CMD_WIDTH-1:0]      cmdinput,
    output logic                      busy,
    output logic [PASS_W-1:0]         pass_idx,
    output logic                      result_valid,
    output logic [ADDER_DATASIZE-1:0] result_data,
    output logic                      err
);

    localparam logic [CMD_WIDTH-1:0] CMD_HOLD   = CMD_WIDTH'(0);
    localparam logic [CMD_WIDTH-1:0] CMD_REDUCE = CMD_WIDTH'(4);
    localparam logic [PASS_W-1:0]    LAST_PASS  = PASS_W'(NPASS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StReduce,
        StCapture,
        StResult
    } state_e;

    state_e                    state_q, state_d;
    logic [CMD_WIDTH-1:0]      cmd_q, cmd_d;
    logic [PASS_W-1:0]         cnt_q, cnt_d;
    logic [1:0]                src_q, src_d;
    logic                      err_q, err_d;
    logic [ADDER_DATASIZE-1:0] data_q, data_d;
    logic                      in_flight;

    assign in_flight = (state_q == StLoad) || (state_q == StReduce) || (state_q == StCapture);

    // cmd_d is the command for the state being entered, so cmdinput lines up with state_q
    always_comb begin
        state_d = state_q;
        cmd_d   = CMD_HOLD;
        cnt_d   = cnt_q;
        src_d   = src_q;
        err_d   = 1'b0;
        data_d  = data_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (src_sel == 2'd3) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = StLoad;
                        src_d   = src_sel;
                        cmd_d   = CMD_WIDTH'(src_sel) + CMD_WIDTH'(1);
                    end
                end
            end
            StLoad: begin
                state_d = StReduce;
                cnt_d   = '0;
                cmd_d   = CMD_REDUCE;
            end
            StReduce: begin
                if (cnt_q == LAST_PASS) begin
                    state_d = StCapture;
                end else begin
                    cnt_d = cnt_q + PASS_W'(1);
                    cmd_d = CMD_REDUCE;
                end
            end
            StCapture: begin
                data_d  = result_pix;
                state_d = StResult;
            end
            StResult: begin
                if (result_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        // Cancel beats every in-flight transition, including the final reduce pass
        if (abort && in_flight) begin
            state_d = StIdle;
            cmd_d   = CMD_HOLD;
            cnt_d   = '0;
            data_d  = data_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cmd_q   <= CMD_HOLD;
            cnt_q   <= '0;
            src_q   <= '0;
            err_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            cnt_q   <= cnt_d;
            src_q   <= src_d;
            err_q   <= err_d;
            data_q  <= data_d;
        end
    end

    assign cmdinput     = cmd_q;
    assign busy         = (state_q != StIdle);
    assign pass_idx     = (state_q == StReduce) ? cnt_q : '0;
    assign result_valid = (state_q == StResult);
    assign result_data  = data_q;
    assign err          = err_q;

`ifdef TREE_SEQ_ACCUM_EN
    localparam int unsigned ACC_W = ADDER_DATASIZE + 8;

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W:0]   acc_sum;
    logic             handshake;

    assign handshake = (state_q == StResult) && result_ready;

    always_comb begin
        acc_sum = {1'b0, acc_q} + (ACC_W + 1)'(data_q);
        acc_d   = acc_q;
        if (acc_clear) begin
            acc_d = '0;
        end else if (handshake) begin
            acc_d = acc_sum[ACC_W] ? '1 : acc_sum[ACC_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) acc_q <= '0;
        else        acc_q <= acc_d;
    end

    assign acc_out = acc_q;
`endif

endmodule

// File: tb/tb_tree_adder_seq.sv
// Self-checking bench for tree_adder_seq: vector table, randomized transactions against a
// cycle-numbered reference model, plus illegal-select, reset and accumulator sequences.
module tb_tree_adder_seq;

    localparam int SIDE = 64;
    localparam int DW   = 16;
    localparam int CW   = 4;
    localparam int P    = $clog2(SIDE);
    localparam int PW   = $clog2(P + 1);

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [1:0]    src_sel;
    logic          abort;
    logic [DW-1:0] result_pix;
    logic          result_ready;
    logic [CW-1:0] cmdinput;
    logic          busy;
    logic [PW-1:0] pass_idx;
    logic          result_valid;
    logic [DW-1:0] result_data;
    logic          err;
`ifdef TREE_SEQ_ACCUM_EN
    logic          acc_clear;
    logic [DW+7:0] acc_out;
    longint        acc_exp;
`endif

    int checks;
    int failures;

    tree_adder_seq #(
        .IMGSIDELENGTH (SIDE),
        .ADDER_DATASIZE(DW),
        .CMD_WIDTH     (CW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .src_sel     (src_sel),
        .abort       (abort),
        .result_pix  (result_pix),
        .result_ready(result_ready),
`ifdef TREE_SEQ_ACCUM_EN
        .acc_clear   (acc_clear),
        .acc_out     (acc_out),
`endif
        .cmdinput    (cmdinput),
        .busy        (busy),
        .pass_idx    (pass_idx),
        .result_valid(result_valid),
        .result_data (result_data),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, " busy"}, 64'(busy), 64'd0);
        chk({tag, " cmd"}, 64'(cmdinput), 64'd0);
        chk({tag, " valid"}, 64'(result_valid), 64'd0);
        chk({tag, " pass"}, 64'(pass_idx), 64'd0);
        chk({tag, " err"}, 64'(err), 64'd0);
`ifdef TREE_SEQ_ACCUM_EN
        chk({tag, " acc"}, 64'(acc_out), 64'(acc_exp));
`endif
    endtask

    // Cycle k counts from the cycle start is sampled. Outputs for cycle k are checked at its
    // falling edge, then inputs for cycle k are driven. Ends after driving the handshake cycle
    // (or the abort cycle); the next call's cycle 0 checks the resulting IDLE.
    task automatic run_txn(input int src, input logic [CW-1:0] load_cmd, input logic [DW-1:0] pix,
                           input int w, input int abort_at, input bit clr_hs);
        int last;
        last = (abort_at >= 0) ? abort_at : P + 3 + w;
        for (int k = 0; k <= last; k++) begin
            @(negedge clk);
            if (k == 0) begin
                check_idle("pre");
            end else begin
                logic [CW-1:0] ecmd;
                logic [PW-1:0] epass;
                logic          evalid;
                string         tag;
                tag    = $sformatf("txn k=%0d", k);
                epass  = '0;
                if (k == 1) ecmd = load_cmd;
                else if (k <= P + 1) begin
                    ecmd  = CW'(4);
                    epass = PW'(k - 2);
                end else ecmd = '0;
                evalid = (k >= P + 3);
                chk({tag, " cmd"}, 64'(cmdinput), 64'(ecmd));
                chk({tag, " busy"}, 64'(busy), 64'd1);
                chk({tag, " pass"}, 64'(pass_idx), 64'(epass));
                chk({tag, " valid"}, 64'(result_valid), 64'(evalid));
                chk({tag, " err"}, 64'(err), 64'd0);
                if (evalid) chk({tag, " data"}, 64'(result_data), 64'(pix));
`ifdef TREE_SEQ_ACCUM_EN
                chk({tag, " acc"}, 64'(acc_out), 64'(acc_exp));
`endif
            end
            start        = (k == 0) ? 1'b1 : ($urandom_range(0, 2) == 0);
            src_sel      = (k == 0) ? 2'(src) : 2'($urandom_range(0, 3));
            abort        = (k == abort_at) ||
                           ((k == 0 || (abort_at < 0 && k >= P + 3)) && ($urandom_range(0, 1) == 1));
            result_ready = (k < P + 3) ? ($urandom_range(0, 1) == 1) : (k >= P + 3 + w);
            result_pix   = (k == P + 2) ? pix : DW'($urandom);
`ifdef TREE_SEQ_ACCUM_EN
            acc_clear = clr_hs && (abort_at < 0) && (k == P + 3 + w);
            if (abort_at < 0 && k == P + 3 + w) begin
                if (acc_clear) acc_exp = 0;
                else begin
                    acc_exp = acc_exp + longint'(pix);
                    if (acc_exp > (64'd1 << (DW + 8)) - 1) acc_exp = (64'd1 << (DW + 8)) - 1;
                end
            end
`else
            if (clr_hs) chk("clr_hs_unsupported", 64'(clr_hs), 64'd0);
`endif
        end
    endtask

    typedef struct {
        int            src;
        logic [DW-1:0] pix;
        int            w;
        int            abort_at;
        logic [CW-1:0] exp_load_cmd;
    } vec_t;

    vec_t vecs[8];

    initial begin
        checks       = 0;
        failures     = 0;
        start        = 1'b0;
        src_sel      = 2'd0;
        abort        = 1'b0;
        result_pix   = '0;
        result_ready = 1'b0;
`ifdef TREE_SEQ_ACCUM_EN
        acc_clear = 1'b0;
        acc_exp   = 0;
`endif
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check_idle("reset");
        chk("reset data", 64'(result_data), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        vecs[0] = '{0, 16'h1234, 0, -1, 4'd1};
        vecs[1] = '{2, 16'hBEEF, 5, -1, 4'd3};
        vecs[2] = '{1, 16'h0F0F, 0, 4, 4'd2};
        vecs[3] = '{1, 16'hA5A5, 1, -1, 4'd2};
        vecs[4] = '{0, 16'h7777, 0, P + 1, 4'd1};
        vecs[5] = '{2, 16'h1111, 0, P + 2, 4'd3};
        vecs[6] = '{1, 16'h0001, 2, 1, 4'd2};
        vecs[7] = '{0, 16'hFFFF, 3, -1, 4'd1};
        for (int i = 0; i < 8; i++) begin
            run_txn(vecs[i].src, vecs[i].exp_load_cmd, vecs[i].pix, vecs[i].w, vecs[i].abort_at,
                    1'b0);
        end

        for (int i = 0; i < 20; i++) begin
            int src;
            int ab;
            src = $urandom_range(0, 2);
            ab  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, P + 2) : -1;
            run_txn(src, CW'(src + 1), DW'($urandom), $urandom_range(0, 4), ab, 1'b0);
        end

        // Illegal plane select: one-cycle err, no activity
        @(negedge clk);
        check_idle("ill pre");
        start   = 1'b1;
        src_sel = 2'd3;
        abort   = 1'b0;
        @(negedge clk);
        chk("ill err", 64'(err), 64'd1);
        chk("ill busy", 64'(busy), 64'd0);
        chk("ill cmd", 64'(cmdinput), 64'd0);
        start = 1'b0;
        @(negedge clk);
        chk("ill err clr", 64'(err), 64'd0);
        chk("ill busy2", 64'(busy), 64'd0);

        // Asynchronous reset in cycle 3 of a request
        start        = 1'b1;
        src_sel      = 2'd0;
        result_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst pre busy", 64'(busy), 64'd1);
        #2 rst_n = 1'b0;
        #1;
`ifdef TREE_SEQ_ACCUM_EN
        acc_exp = 0;
`endif
        check_idle("rst mid");
        chk("rst mid data", 64'(result_data), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_txn(1, 4'd2, 16'h4242, 0, -1, 1'b0);

`ifdef TREE_SEQ_ACCUM_EN
        @(negedge clk);
        acc_clear = 1'b1;
        acc_exp   = 0;
        @(negedge clk);
        acc_clear = 1'b0;
        chk("acc cleared", 64'(acc_out), 64'd0);
        run_txn(0, 4'd1, 16'hFFFF, 0, -1, 1'b0);
        run_txn(1, 4'd2, 16'h0001, 1, -1, 1'b0);
        @(negedge clk);
        chk("acc two results", 64'(acc_out), 64'h010000);
        run_txn(2, 4'd3, 16'h0055, 0, -1, 1'b1);
        @(negedge clk);
        chk("acc clr wins", 64'(acc_out), 64'd0);
`endif

        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        result_ready = 1'b0;
`ifdef TREE_SEQ_ACCUM_EN
        acc_clear = 1'b0;
`endif
        check_idle("final");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
